// File: rtl/tmp75_ctrl.sv
// rtl/tmp75_ctrl.sv - TMP75 config + periodic temperature read sequencer for i2c_dri (optional over-temp flag: TMP75_OT_EN)
module tmp75_ctrl #(
  parameter logic [6:0]  DEV_ADDR      = 7'h48,
  parameter logic [7:0]  CFG_BYTE      = 8'h60,
  parameter logic [31:0] SAMPLE_PERIOD = 32'd10_000_000,
  parameter logic [15:0] TIMEOUT       = 16'd4096
`ifdef TMP75_OT_EN
  ,
  parameter logic signed [11:0] T_HIGH = 12'sh500,
  parameter logic signed [11:0] T_LOW  = 12'sh4B0
`endif
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  output logic [23:0] wr_data_o,
  output logic [7:0]  wr_cnt_o,
  output logic [7:0]  rd_cnt_o,
  output logic        iic_en_o,
  output logic        iic_mode_o,
  input  logic        iic_busy_i,
  input  logic [15:0] rd_data_i,
  output logic [11:0] temp_o,
  output logic        temp_vld_o,
  output logic        cfg_done_o,
  output logic        err_o,
  output logic        ot_o
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CFG_REQ  = 3'd1,
    CFG_WAIT = 3'd2,
    PERIOD   = 3'd3,
    RD_REQ   = 3'd4,
    RD_WAIT  = 3'd5,
    LATCH    = 3'd6
  } state_t;

  localparam logic [31:0] PERIOD_LAST = SAMPLE_PERIOD - 32'd1;
  localparam logic [31:0] TO_LAST     = {16'd0, TIMEOUT} - 32'd1;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_busy_meta;
  logic        r_busy_s;
  logic [31:0] r_cnt;
  logic [11:0] r_temp;
  logic        r_cfg_done;
  logic        r_err;
  logic        w_timeout;
  logic        w_cfg_set;
  logic        w_latch;
  logic        w_cnt_run;
  logic [11:0] w_temp_new;
  logic        w_unused;

  // TMP75 sends MSB first: byte0 = T[11:4], byte1[7:4] = T[3:0]
  assign w_temp_new = {rd_data_i[7:0], rd_data_i[15:12]};
  assign w_unused   = ^rd_data_i[11:8];

  // Two-flop resync of busy; resets to 1 so a frame still running in i2c_dri
  // (which has no reset) is never mistaken for idle right after reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_busy_meta <= 1'b1;
      r_busy_s    <= 1'b1;
    end else begin
      r_busy_meta <= iic_busy_i;
      r_busy_s    <= r_busy_meta;
    end
  end

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, request fields and datapath strobes
  always_comb begin
    w_state_nxt = r_state;
    w_timeout   = 1'b0;
    w_cfg_set   = 1'b0;
    w_latch     = 1'b0;
    w_cnt_run   = 1'b0;
    wr_data_o   = 24'd0;
    wr_cnt_o    = 8'd0;
    rd_cnt_o    = 8'd0;
    iic_mode_o  = 1'b0;
    iic_en_o    = 1'b0;
    temp_vld_o  = 1'b0;
    case (r_state)
      IDLE: begin
        if (en_i && !r_busy_s) begin
          w_state_nxt = r_cfg_done ? PERIOD : CFG_REQ;
        end
      end
      CFG_REQ, CFG_WAIT: begin
        wr_data_o = {CFG_BYTE, 8'h01, DEV_ADDR, 1'b0};
        wr_cnt_o  = 8'd3;
        iic_en_o  = (r_state == CFG_REQ);
        if (r_state == CFG_REQ) begin
          w_cnt_run = 1'b1;
          if (r_busy_s) begin
            w_state_nxt = CFG_WAIT;
          end else if (r_cnt == TO_LAST) begin
            w_state_nxt = IDLE;
            w_timeout   = 1'b1;
          end
        end else if (!r_busy_s) begin
          w_state_nxt = PERIOD;
          w_cfg_set   = 1'b1;
        end
      end
      PERIOD: begin
        w_cnt_run = 1'b1;
        if (!en_i) begin
          w_state_nxt = IDLE;
        end else if (r_cnt == PERIOD_LAST) begin
          w_state_nxt = RD_REQ;
        end
      end
      RD_REQ, RD_WAIT: begin
        wr_data_o  = {8'h00, 8'h00, DEV_ADDR, 1'b0};
        wr_cnt_o   = 8'd2;
        rd_cnt_o   = 8'd2;
        iic_mode_o = 1'b1;
        iic_en_o   = (r_state == RD_REQ);
        if (r_state == RD_REQ) begin
          w_cnt_run = 1'b1;
          if (r_busy_s) begin
            w_state_nxt = RD_WAIT;
          end else if (r_cnt == TO_LAST) begin
            w_state_nxt = IDLE;
            w_timeout   = 1'b1;
          end
        end else if (!r_busy_s) begin
          w_state_nxt = LATCH;
          w_latch     = 1'b1;
        end
      end
      LATCH: begin
        temp_vld_o  = 1'b1;
        w_state_nxt = PERIOD;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Shared cycle counter: period wait and request timeout; restarts on every state change
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= 32'd0;
    end else if (w_state_nxt != r_state) begin
      r_cnt <= 32'd0;
    end else if (w_cnt_run) begin
      r_cnt <= r_cnt + 32'd1;
    end
  end

  // Temperature captured as the frame ends so it is valid alongside the LATCH strobe
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_temp     <= 12'd0;
      r_cfg_done <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      if (w_latch) begin
        r_temp <= w_temp_new;
      end
      if (w_cfg_set) begin
        r_cfg_done <= 1'b1;
      end
      if (w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

  assign temp_o     = r_temp;
  assign cfg_done_o = r_cfg_done;
  assign err_o      = r_err;

`ifdef TMP75_OT_EN
  logic r_ot;

  // Hysteretic over-temperature flag, evaluated on the fresh sample
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ot <= 1'b0;
    end else if (w_latch) begin
      if ($signed(w_temp_new) >= T_HIGH) begin
        r_ot <= 1'b1;
      end else if ($signed(w_temp_new) <= T_LOW) begin
        r_ot <= 1'b0;
      end
    end
  end

  assign ot_o = r_ot;
`else
  assign ot_o = 1'b0;
`endif

endmodule
